rv32_hazard_scoreboard: RTL and testbench

Parametrised register scoreboard for the RV32I pipeline. It tracks in-flight destination-register writes between issue (ID→EX) and writeback, and it blocks issue on RAW hazards and on counter saturation. It sits beside pipID/pipEX at core level: decode offers each instruction and the block grants or withholds issue; WB and squash events retire entries. It replaces the core's current assumption of no hazards, and it counts stall cycles for performance tuning.

---
 rtl/rv32_hazard_scoreboard.sv | 152 +++++++++++++++
 tb/tb_rv32_hazard_scoreboard.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_hazard_scoreboard.sv
// rv32_hazard_scoreboard
//
// Register scoreboard for the RV32I pipeline. Each architectural register
// (except x0) has a small pending-write counter. The counter goes up when an
// instruction that writes the register issues. It goes down when that write
// reaches writeback or is squashed. Decode offers one instruction per cycle.
// The block grants issue only when:
//   - no source the instruction reads has a write still in flight, and
//   - the destination counter is not already saturated.
//
// Ports
//   iCLK, iRST       clock, synchronous active-high reset
//   iIssueValid      decode is offering an instruction
//   iIssueRs1/Rs2    source register addresses
//   iUseRs1/Rs2      the instruction actually reads that source
//   iIssueRd         destination register address
//   iWritesRd        the instruction writes its destination
//   iHold            external pipeline freeze; blocks issue and stall counting
//   oIssueReady      combinational: the offered instruction may issue
//   iWbValid/iWbRd   writeback retiring one pending write
//   iKillValid/Rd    squash of an in-flight writing instruction
//   oBusy            at least one write is still pending
//   oError           sticky: a counter would have gone below zero
//   oStallCnt        saturating count of hazard-stall cycles
module rv32_hazard_scoreboard #(
    parameter int NREG      = 32,
    parameter int RA_W      = 5,
    parameter int CNT_W     = 2,
    parameter int WB_BYPASS = 1,
    parameter int STALL_W   = 16
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iIssueValid,
    input  logic [RA_W-1:0]    iIssueRs1,
    input  logic [RA_W-1:0]    iIssueRs2,
    input  logic               iUseRs1,
    input  logic               iUseRs2,
    input  logic [RA_W-1:0]    iIssueRd,
    input  logic               iWritesRd,
    input  logic               iHold,
    output logic               oIssueReady,
    input  logic               iWbValid,
    input  logic [RA_W-1:0]    iWbRd,
    input  logic               iKillValid,
    input  logic [RA_W-1:0]    iKillRd,
    output logic               oBusy,
    output logic               oError,
    output logic [STALL_W-1:0] oStallCnt
);

    localparam int EXT_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt      [NREG];
    logic [CNT_W-1:0] cnt_next [NREG];
    logic [NREG-1:0]  underflow;
    logic             hazard_rs1;
    logic             hazard_rs2;
    logic             saturated;
    logic             fire;
    logic             stall;
    logic             error_q;
    logic [STALL_W-1:0] stall_cnt;

    // A source is blocked while its counter is non-zero. The exception is a
    // same-cycle writeback that retires the last pending write. This path
    // deliberately ignores iIssueValid and iHold, so decode can safely
    // depend on oIssueReady.
    always_comb begin
        hazard_rs1 = 1'b0;
        hazard_rs2 = 1'b0;
        if (iUseRs1 && iIssueRs1 != '0 && cnt[iIssueRs1] != '0) begin
            hazard_rs1 = 1'b1;
            if (WB_BYPASS != 0 && iWbValid && iWbRd == iIssueRs1 && cnt[iIssueRs1] == CNT_ONE) begin
                hazard_rs1 = 1'b0;
            end
        end
        if (iUseRs2 && iIssueRs2 != '0 && cnt[iIssueRs2] != '0) begin
            hazard_rs2 = 1'b1;
            if (WB_BYPASS != 0 && iWbValid && iWbRd == iIssueRs2 && cnt[iIssueRs2] == CNT_ONE) begin
                hazard_rs2 = 1'b0;
            end
        end
        saturated = iWritesRd && iIssueRd != '0 && cnt[iIssueRd] == CNT_MAX;
    end

    assign oIssueReady = ~hazard_rs1 & ~hazard_rs2 & ~saturated;
    assign fire        = iIssueValid & oIssueReady & ~iHold;
    assign stall       = iIssueValid & ~oIssueReady & ~iHold;

    // Next counter values. The sum is formed two bits wider than the counter,
    // so a double decrement of a counter at 0 or 1 shows up as a set MSB.
    // Saturation blocking means the increment can never overflow.
    always_comb begin
        logic [EXT_W-1:0] inc;
        logic [EXT_W-1:0] dec;
        logic [EXT_W-1:0] sum;
        inc = '0;
        dec = '0;
        sum = '0;
        cnt_next[0]  = '0;
        underflow    = '0;
        for (int r = 1; r < NREG; r++) begin
            inc = EXT_W'(fire && iWritesRd && iIssueRd == RA_W'(r));
            dec = EXT_W'(iWbValid && iWbRd == RA_W'(r))
                + EXT_W'(iKillValid && iKillRd == RA_W'(r));
            sum = {2'b00, cnt[r]} + inc - dec;
            if (sum[EXT_W-1]) begin
                cnt_next[r]  = '0;
                underflow[r] = 1'b1;
            end else begin
                cnt_next[r]  = sum[CNT_W-1:0];
            end
        end
    end

    // State update. Reset wins over every concurrent event and discards
    // anything that was still pending.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            error_q   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= cnt_next[r];
            end
            if (|underflow) begin
                error_q <= 1'b1;
            end
            if (stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
        end
    end

    // Busy is the OR of the registered counters.
    always_comb begin
        oBusy = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            oBusy = oBusy | (cnt[r] != '0);
        end
    end

    assign oError    = error_q;
    assign oStallCnt = stall_cnt;

endmodule

// File: tb/tb_rv32_hazard_scoreboard.sv
// tb_rv32_hazard_scoreboard
//
// Directed testbench for rv32_hazard_scoreboard.
//
// A behavioural model keeps one integer pending count per register, plus an
// error bit and a stall count. It derives the expected outputs from those
// counts and the current inputs. A compare process checks every DUT output
// against the model on each falling edge. The directed sequence adds
// hand-computed literal checks at the interesting points.
module tb_rv32_hazard_scoreboard;

    localparam int NREG    = 32;
    localparam int RA_W    = 5;
    localparam int CNT_W   = 2;
    localparam int BYPASS  = 1;
    localparam int STALL_W = 16;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int SMAX    = (1 << STALL_W) - 1;

    logic               iCLK = 1'b0;
    logic               iRST = 1'b0;
    logic               iIssueValid = 1'b0;
    logic [RA_W-1:0]    iIssueRs1 = '0;
    logic [RA_W-1:0]    iIssueRs2 = '0;
    logic               iUseRs1 = 1'b0;
    logic               iUseRs2 = 1'b0;
    logic [RA_W-1:0]    iIssueRd = '0;
    logic               iWritesRd = 1'b0;
    logic               iHold = 1'b0;
    logic               oIssueReady;
    logic               iWbValid = 1'b0;
    logic [RA_W-1:0]    iWbRd = '0;
    logic               iKillValid = 1'b0;
    logic [RA_W-1:0]    iKillRd = '0;
    logic               oBusy;
    logic               oError;
    logic [STALL_W-1:0] oStallCnt;

    int tests_run = 0;
    int tests_failed = 0;

    int model_cnt [NREG];
    bit model_err = 1'b0;
    int model_stall = 0;
    bit model_live = 1'b0;

    rv32_hazard_scoreboard #(
        .NREG(NREG), .RA_W(RA_W), .CNT_W(CNT_W), .WB_BYPASS(BYPASS), .STALL_W(STALL_W)
    ) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iIssueValid(iIssueValid), .iIssueRs1(iIssueRs1), .iIssueRs2(iIssueRs2),
        .iUseRs1(iUseRs1), .iUseRs2(iUseRs2), .iIssueRd(iIssueRd), .iWritesRd(iWritesRd),
        .iHold(iHold), .oIssueReady(oIssueReady),
        .iWbValid(iWbValid), .iWbRd(iWbRd), .iKillValid(iKillValid), .iKillRd(iKillRd),
        .oBusy(oBusy), .oError(oError), .oStallCnt(oStallCnt)
    );

    always #5 iCLK = ~iCLK;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Model rules: a read source is blocked while writes to it are pending,
    // unless bypass is on and this cycle's writeback retires the last one.
    function automatic bit model_src_blocked(input int s, input bit used);
        if (!used || s == 0) return 1'b0;
        if (model_cnt[s] == 0) return 1'b0;
        if (BYPASS != 0 && iWbValid && int'(iWbRd) == s && model_cnt[s] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_ready();
        bit full;
        full = iWritesRd && iIssueRd != 0 && model_cnt[iIssueRd] == CMAX;
        return !model_src_blocked(int'(iIssueRs1), iUseRs1)
            && !model_src_blocked(int'(iIssueRs2), iUseRs2) && !full;
    endfunction

    function automatic bit model_busy();
        for (int r = 0; r < NREG; r++) if (model_cnt[r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Model update: net pending change per register this cycle.
    always @(posedge iCLK) begin
        bit rdy;
        bit fire;
        int d;
        if (iRST) begin
            for (int r = 0; r < NREG; r++) model_cnt[r] <= 0;
            model_err   <= 1'b0;
            model_stall <= 0;
            model_live  <= 1'b1;
        end else if (model_live) begin
            rdy  = model_ready();
            fire = iIssueValid && rdy && !iHold;
            for (int r = 1; r < NREG; r++) begin
                d = model_cnt[r];
                if (fire && iWritesRd && int'(iIssueRd) == r) d = d + 1;
                if (iWbValid && int'(iWbRd) == r) d = d - 1;
                if (iKillValid && int'(iKillRd) == r) d = d - 1;
                if (d < 0) begin
                    d = 0;
                    model_err <= 1'b1;
                end
                model_cnt[r] <= d;
            end
            if (iIssueValid && !rdy && !iHold && model_stall < SMAX)
                model_stall <= model_stall + 1;
        end
    end

    // Compare process: every output against the model on each falling edge.
    always @(negedge iCLK) begin
        if (model_live) begin
            checkOutput("model_ready", int'(oIssueReady), int'(model_ready()));
            checkOutput("model_busy", int'(oBusy), int'(model_busy()));
            checkOutput("model_error", int'(oError), int'(model_err));
            checkOutput("model_stall", int'(oStallCnt), model_stall);
        end
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic applyStimulus(input bit v, input int rs1, input bit u1, input int rs2,
                                 input bit u2, input int rd, input bit w, input bit hold,
                                 input bit wbv, input int wbrd, input bit kv, input int krd);
        iIssueValid = v;
        iIssueRs1   = RA_W'(rs1);
        iUseRs1     = u1;
        iIssueRs2   = RA_W'(rs2);
        iUseRs2     = u2;
        iIssueRd    = RA_W'(rd);
        iWritesRd   = w;
        iHold       = hold;
        iWbValid    = wbv;
        iWbRd       = RA_W'(wbrd);
        iKillValid  = kv;
        iKillRd     = RA_W'(krd);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issue_rd(input int rd);
        applyStimulus(1, 0, 0, 0, 0, rd, 1, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic wb_rd(input int rd);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, rd, 0, 0);
        tick();
    endtask

    initial begin
        // Reset and idle
        idle();
        iRST = 1'b1;
        tick();
        tick();
        iRST = 1'b0;
        #1;
        checkOutput("reset_busy", int'(oBusy), 0);
        checkOutput("reset_error", int'(oError), 0);
        checkOutput("reset_stall", int'(oStallCnt), 0);

        // Writeback/kill to x0 are ignored
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        tick();
        checkOutput("x0_wb_no_error", int'(oError), 0);

        applyStimulus(1, 0, 1, 0, 1, 5, 1, 0, 0, 0, 0, 0);
        checkOutput("idle_issue_ready", int'(oIssueReady), 1);
        tick();
        idle();
        checkOutput("rd5_pending_busy", int'(oBusy), 1);
        wb_rd(5);

        // RAW stall and release
        issue_rd(3);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 3, 1, 0, 0, 10, 1, 0, 0, 0, 0, 0);
            checkOutput("raw_blocked", int'(oIssueReady), 0);
            tick();
        end
        idle();
        checkOutput("raw_stall_3", int'(oStallCnt), 3);
        applyStimulus(1, 3, 1, 0, 0, 10, 1, 0, 1, 3, 0, 0);
        checkOutput("raw_wb_cycle", int'(oIssueReady), BYPASS);
        tick();
        if (BYPASS == 0) begin
            applyStimulus(1, 3, 1, 0, 0, 10, 1, 0, 0, 0, 0, 0);
            checkOutput("raw_after_wb", int'(oIssueReady), 1);
            tick();
        end
        idle();
        checkOutput("raw_total_stall", int'(oStallCnt), (BYPASS != 0) ? 3 : 4);
        wb_rd(10);
        idle();
        checkOutput("drained_busy", int'(oBusy), 0);

        // x0 destination and unused source
        issue_rd(0);
        idle();
        checkOutput("x0_not_tracked", int'(oBusy), 0);
        issue_rd(7);
        applyStimulus(1, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("unused_rs2_ready", int'(oIssueReady), 1);
        applyStimulus(0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("used_rs2_blocked", int'(oIssueReady), 0);
        wb_rd(7);

        // Saturation
        issue_rd(9);
        issue_rd(9);
        issue_rd(9);
        applyStimulus(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0);
        checkOutput("sat_blocked", int'(oIssueReady), 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 9, 1, 0, 1, 9, 0, 0);
        checkOutput("sat_blocked_during_wb", int'(oIssueReady), 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0);
        checkOutput("sat_released", int'(oIssueReady), 1);
        tick();
        idle();
        checkOutput("sat_stall_total", int'(oStallCnt), (BYPASS != 0) ? 5 : 6);
        wb_rd(9);
        wb_rd(9);
        wb_rd(9);

        // Issue + WB + kill on one register: net -1
        issue_rd(4);
        issue_rd(4);
        applyStimulus(1, 0, 0, 0, 0, 4, 1, 0, 1, 4, 1, 4);
        tick();
        applyStimulus(0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("triple_still_pending", int'(oIssueReady), 0);
        applyStimulus(0, 4, 1, 0, 0, 0, 0, 0, 1, 4, 0, 0);
        checkOutput("triple_cnt_is_one", int'(oIssueReady), (BYPASS != 0) ? 1 : 0);
        tick();

        // WB + kill on a count of one underflows
        issue_rd(6);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 1, 6);
        tick();
        idle();
        checkOutput("underflow_error", int'(oError), 1);
        checkOutput("underflow_cleared", int'(oBusy), 0);
        tick();
        tick();
        checkOutput("error_sticky", int'(oError), 1);

        // Hold with a hazard, then mid-operation reset
        issue_rd(2);
        issue_rd(2);
        applyStimulus(1, 2, 1, 0, 0, 11, 1, 1, 0, 0, 0, 0);
        checkOutput("hold_hazard_ready", int'(oIssueReady), 0);
        tick();
        tick();
        idle();
        checkOutput("hold_no_stall", int'(oStallCnt), (BYPASS != 0) ? 5 : 6);
        iRST = 1'b1;
        applyStimulus(1, 2, 1, 0, 0, 2, 1, 0, 1, 2, 1, 2);
        tick();
        iRST = 1'b0;
        idle();
        checkOutput("midreset_busy", int'(oBusy), 0);
        checkOutput("midreset_error", int'(oError), 0);
        checkOutput("midreset_stall", int'(oStallCnt), 0);
        applyStimulus(1, 2, 1, 2, 1, 2, 1, 0, 0, 0, 0, 0);
        checkOutput("midreset_ready", int'(oIssueReady), 1);
        tick();
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
